// File: rtl/atm_pkg.sv
// Shared constants, state encoding and account table for the ATM card/PIN
// authentication stage.
package atm_pkg;

    localparam int unsigned CARD_W = 32;
    localparam int unsigned PIN_W  = 20;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_LOOKUP   = 3'd1;
    localparam state_t ST_WAIT_PIN = 3'd2;
    localparam state_t ST_CHECK    = 3'd3;
    localparam state_t ST_AUTH     = 3'd4;

    function automatic logic [CARD_W-1:0] acct_card(input int unsigned idx);
        case (idx)
            0:       acct_card = 32'd11112222;
            1:       acct_card = 32'd33334444;
            2:       acct_card = 32'd55556666;
            3:       acct_card = 32'd77778888;
            default: acct_card = '0;
        endcase
    endfunction

    function automatic logic [PIN_W-1:0] acct_pin(input int unsigned idx);
        case (idx)
            0:       acct_pin = 20'd5432;
            1:       acct_pin = 20'd1234;
            2:       acct_pin = 20'd9999;
            3:       acct_pin = 20'd0;
            default: acct_pin = '0;
        endcase
    endfunction

endpackage

// File: rtl/atm_lockout_ctr.sv
// Per-account wrong-PIN attempt counters and lock bits, addressed by account
// index; supports decrement (locking on the last try) and restore.
module atm_lockout_ctr
    import atm_pkg::*;
#(
    parameter int unsigned NUM_ACCOUNTS = 4,
    parameter int unsigned MAX_ATTEMPTS = 3,
    parameter int unsigned IDX_W        = 2,
    parameter int unsigned CNT_W        = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_dec,
    input  logic             i_restore,
    output logic [CNT_W-1:0] o_count,
    output logic             o_locked
);

    logic [CNT_W-1:0]        r_count [NUM_ACCOUNTS];
    logic [NUM_ACCOUNTS-1:0] r_lock;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                r_count[i] <= CNT_W'(MAX_ATTEMPTS);
            end
            r_lock <= '0;
        end else if (i_restore) begin
            r_count[i_idx] <= CNT_W'(MAX_ATTEMPTS);
        end else if (i_dec && (r_count[i_idx] != '0)) begin
            r_count[i_idx] <= r_count[i_idx] - CNT_W'(1);
            // Last remaining try consumed: the account locks permanently until reset.
            if (r_count[i_idx] == CNT_W'(1)) begin
                r_lock[i_idx] <= 1'b1;
            end
        end
    end

    assign o_count  = r_count[i_idx];
    assign o_locked = r_lock[i_idx];

endmodule

// File: rtl/atm_pin_auth.sv
// Card lookup + PIN check FSM with per-account lockout. Defining
// ATM_PIN_TIMEOUT_EN adds a WAIT_PIN inactivity timeout of TIMEOUT_CYCLES.
module atm_pin_auth
    import atm_pkg::*;
#(
    parameter int unsigned NUM_ACCOUNTS   = 4,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned IDX_W          = $clog2(NUM_ACCOUNTS),
    parameter int unsigned CNT_W          = $clog2(MAX_ATTEMPTS + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_card_valid,
    input  logic [CARD_W-1:0] i_cardnumber,
    input  logic              i_pin_valid,
    input  logic [PIN_W-1:0]  i_pin,
    input  logic              i_logout,
    output logic              o_auth_ok,
    output logic [IDX_W-1:0]  o_acct_idx,
    output logic              o_card_unknown,
    output logic              o_pin_error,
    output logic              o_locked,
    output logic [CNT_W-1:0]  o_attempts_left,
    output logic              o_busy,
    output logic              o_timeout
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACCOUNTS - 1);

    state_t            r_state;
    logic [CARD_W-1:0] r_card;
    logic [PIN_W-1:0]  r_pin;
    logic [IDX_W-1:0]  r_idx;
    logic              r_auth_ok;
    logic [IDX_W-1:0]  r_acct_idx;
    logic              r_card_unknown;
    logic              r_pin_error;
    logic              r_locked;
    logic [CNT_W-1:0]  r_attempts_left;

    logic              w_card_hit;
    logic              w_pin_hit;
    logic              w_dec;
    logic              w_restore;
    logic [CNT_W-1:0]  w_count;
    logic              w_acct_locked;
    logic              w_tmo_hit;

    // r_idx walks the table during LOOKUP and then holds the matched account.
    assign w_card_hit = (r_card == acct_card(32'(r_idx)));
    assign w_pin_hit  = (r_pin == acct_pin(32'(r_idx)));
    assign w_dec      = (r_state == ST_CHECK) && i_start && !w_pin_hit;
    assign w_restore  = (r_state == ST_CHECK) && i_start && w_pin_hit;

    atm_lockout_ctr #(
        .NUM_ACCOUNTS (NUM_ACCOUNTS),
        .MAX_ATTEMPTS (MAX_ATTEMPTS),
        .IDX_W        (IDX_W),
        .CNT_W        (CNT_W)
    ) u_lockout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_idx     (r_idx),
        .i_dec     (w_dec),
        .i_restore (w_restore),
        .o_count   (w_count),
        .o_locked  (w_acct_locked)
    );

`ifdef ATM_PIN_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timeout;

    assign w_tmo_hit = i_start && !i_pin_valid && (r_state == ST_WAIT_PIN) &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Counter is zero on every WAIT_PIN entry since it is cleared in all other states.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_tmo_hit;
            if (r_state == ST_WAIT_PIN) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_tmo_hit = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_card          <= '0;
            r_pin           <= '0;
            r_idx           <= '0;
            r_auth_ok       <= 1'b0;
            r_acct_idx      <= '0;
            r_card_unknown  <= 1'b0;
            r_pin_error     <= 1'b0;
            r_locked        <= 1'b0;
            r_attempts_left <= '0;
        end else begin
            r_card_unknown <= 1'b0;
            r_pin_error    <= 1'b0;
            r_locked       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start && i_card_valid) begin
                        r_card  <= i_cardnumber;
                        r_idx   <= '0;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (!i_start) begin
                        r_state <= ST_IDLE;
                    end else if (w_card_hit) begin
                        r_attempts_left <= w_count;
                        if (w_acct_locked) begin
                            r_locked <= 1'b1;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT_PIN;
                        end
                    end else if (r_idx == LAST_IDX) begin
                        r_card_unknown <= 1'b1;
                        r_state        <= ST_IDLE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_WAIT_PIN: begin
                    if (!i_start || w_tmo_hit) begin
                        r_state <= ST_IDLE;
                    end else if (i_pin_valid) begin
                        r_pin   <= i_pin;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!i_start) begin
                        r_state <= ST_IDLE;
                    end else if (w_pin_hit) begin
                        r_auth_ok       <= 1'b1;
                        r_acct_idx      <= r_idx;
                        r_attempts_left <= CNT_W'(MAX_ATTEMPTS);
                        r_state         <= ST_AUTH;
                    end else begin
                        r_pin_error     <= 1'b1;
                        r_attempts_left <= w_count - CNT_W'(1);
                        if (w_count == CNT_W'(1)) begin
                            r_locked <= 1'b1;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT_PIN;
                        end
                    end
                end
                ST_AUTH: begin
                    if (!i_start || i_logout) begin
                        r_auth_ok  <= 1'b0;
                        r_acct_idx <= '0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_auth_ok       = r_auth_ok;
    assign o_acct_idx      = r_acct_idx;
    assign o_card_unknown  = r_card_unknown;
    assign o_pin_error     = r_pin_error;
    assign o_locked        = r_locked;
    assign o_attempts_left = r_attempts_left;
    assign o_busy          = (r_state != ST_IDLE);

endmodule
